// File: rtl/conv_mac_acc_if.sv
// Purpose: beat/result bundle for conv_mac_acc.
//   master (window generator side) drives in_valid, win_flat, wgt_flat and bias, and
//   observes ch_idx, out_valid and out_data.
//   slave (conv_mac_acc) does the reverse.
// Parameters must match the conv_mac_acc instance the bundle is bound to.
interface conv_mac_acc_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned KSIZE  = 3,
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned OUT_W  = 16
);
   localparam int unsigned TAPS = KSIZE * KSIZE;
   localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic                     in_valid;
   logic [TAPS*DATA_W-1:0]   win_flat;
   logic [TAPS*DATA_W-1:0]   wgt_flat;
   logic signed [DATA_W-1:0] bias;
   logic [CH_W-1:0]          ch_idx;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;

   modport master (
      output in_valid, win_flat, wgt_flat, bias,
      input  ch_idx, out_valid, out_data
   );

   modport slave (
      input  in_valid, win_flat, wgt_flat, bias,
      output ch_idx, out_valid, out_data
   );
endinterface

// File: rtl/conv_mac_acc.sv
// Purpose: KxK convolution MAC. Each accepted beat carries one window and one kernel.
//   The kernel is flipped (true convolution), the products are summed in a registered
//   pairwise adder tree, and CH_NUM channel beats are accumulated into one pixel.
//   Bias is added on the first channel beat. The pixel result is saturated to OUT_W
//   and strobed out once per pixel.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - conv_mac_acc_if.slave
//          (in_valid, win_flat, wgt_flat, bias in; ch_idx, out_valid, out_data out)
// Pipeline: input capture, multiply, clog2(TAPS) tree levels, accumulate, output.
//   out_valid rises S+3 clocks after the edge that accepts the last channel beat.
// Build option: define CONV_MAC_RELU_EN to clamp negative results to zero after saturation.
module conv_mac_acc #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned KSIZE  = 3,
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned OUT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   conv_mac_acc_if.slave bus
);
   localparam int unsigned TAPS   = KSIZE * KSIZE;
   localparam int unsigned S      = $clog2(TAPS);
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SUM_W  = PROD_W + S;
   localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // Number of nodes on tree level lvl (level 0 = products).
   function automatic int unsigned nodes(input int unsigned lvl);
      return (TAPS + (32'd1 << lvl) - 32'd1) >> lvl;
   endfunction

   // Input capture and channel counter.
   logic                     r_in_vld, r_in_first, r_in_last;
   logic [TAPS*DATA_W-1:0]   r_win, r_wgt;
   logic signed [DATA_W-1:0] r_in_bias;
   logic [CH_W-1:0]          r_ch;
   logic                     w_first, w_last;

   assign w_first = (r_ch == '0);
   assign w_last  = (r_ch == CH_W'(CH_NUM - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch       <= '0;
         r_in_vld   <= 1'b0;
         r_in_first <= 1'b0;
         r_in_last  <= 1'b0;
         r_win      <= '0;
         r_wgt      <= '0;
         r_in_bias  <= '0;
      end else begin
         r_in_vld <= bus.in_valid;
         if (bus.in_valid) begin
            r_ch       <= w_last ? '0 : r_ch + CH_W'(1);
            r_in_first <= w_first;
            r_in_last  <= w_last;
            r_win      <= bus.win_flat;
            r_wgt      <= bus.wgt_flat;
            r_in_bias  <= bus.bias;
         end
      end
   end

   // Beat tags travel alongside the tree; index k = tree level k.
   logic [S:0]               r_vld, r_first, r_last;
   logic signed [DATA_W-1:0] r_bias [S+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= '0;
         r_first <= '0;
         r_last  <= '0;
         for (int k = 0; k <= int'(S); k++) r_bias[k] <= '0;
      end else begin
         r_vld[0]   <= r_in_vld;
         r_first[0] <= r_in_first;
         r_last[0]  <= r_in_last;
         r_bias[0]  <= r_in_bias;
         for (int k = 1; k <= int'(S); k++) begin
            r_vld[k]   <= r_vld[k-1];
            r_first[k] <= r_first[k-1];
            r_last[k]  <= r_last[k-1];
            r_bias[k]  <= r_bias[k-1];
         end
      end
   end

   // Level 0: flipped-kernel products; levels 1..S: pairwise adds, each one bit wider.
   // Datapath registers run freely; only the tags decide what is consumed.
   for (genvar l = 0; l <= S; l++) begin : g_lvl
      localparam int unsigned NW = PROD_W + l;
      localparam int unsigned NN = nodes(l);
      logic signed [NW-1:0] r_node [NN];

      if (l == 0) begin : g_mul
         for (genvar j = 0; j < NN; j++) begin : g_node
            logic signed [PROD_W-1:0] w_a, w_b;
            assign w_a = PROD_W'($signed(r_win[j*DATA_W +: DATA_W]));
            assign w_b = PROD_W'($signed(r_wgt[(TAPS-1-j)*DATA_W +: DATA_W]));
            always_ff @(posedge clk) r_node[j] <= w_a * w_b;
         end
      end else begin : g_add
         localparam int unsigned PN = nodes(l - 1);
         for (genvar j = 0; j < NN; j++) begin : g_node
            if (2*j + 1 < PN) begin : g_pair
               always_ff @(posedge clk)
                  r_node[j] <= NW'(g_lvl[l-1].r_node[2*j]) + NW'(g_lvl[l-1].r_node[2*j+1]);
            end else begin : g_pass
               always_ff @(posedge clk) r_node[j] <= NW'(g_lvl[l-1].r_node[2*j]);
            end
         end
      end
   end

   logic signed [SUM_W-1:0] w_tree;
   assign w_tree = g_lvl[S].r_node[0];

   // Accumulator: first channel reloads with sum+bias, so nothing leaks between pixels.
   logic signed [ACC_W-1:0] w_sum, w_bias_ext, w_acc_next, r_acc;
   logic                    r_acc_vld;

   always_comb begin
      w_sum      = ACC_W'(w_tree);
      w_bias_ext = ACC_W'(r_bias[S]);
      w_acc_next = r_first[S] ? (w_sum + w_bias_ext) : (r_acc + w_sum);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_acc_vld <= 1'b0;
      end else begin
         r_acc_vld <= r_vld[S] & r_last[S];
         if (r_vld[S]) r_acc <= w_acc_next;
      end
   end

   // Saturating narrow of the finished pixel, optional ReLU.
   logic signed [OUT_W-1:0] w_sat, w_res;

   always_comb begin
      if (r_acc > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
      else if (r_acc < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
      else                      w_sat = r_acc[OUT_W-1:0];
`ifdef CONV_MAC_RELU_EN
      w_res = w_sat[OUT_W-1] ? '0 : w_sat;
`else
      w_res = w_sat;
`endif
   end

   logic                    r_out_valid;
   logic signed [OUT_W-1:0] r_out_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= r_acc_vld;
         if (r_acc_vld) r_out_data <= w_res;
      end
   end

   assign bus.ch_idx    = r_ch;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_conv_mac_acc.sv
// Purpose: self-checking bench for conv_mac_acc. Two instances share identical input
//   beats: one with CH_NUM=4 and one with CH_NUM=1. Expected pixels come from hand
//   tables or from an arithmetic model and are compared at the negedge, including the
//   strobe timing.
module tb_conv_mac_acc;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned KSIZE  = 3;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned OUT_W  = 16;
   localparam longint      PER    = 10;
   localparam longint      LAT    = 7;

   typedef logic [71:0] flat_t;
   typedef struct { int val; longint t; } exp_t;
   typedef struct { flat_t win; flat_t wgt; logic signed [7:0] bias; int exp; } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_mac_acc_if #(.DATA_W(DATA_W), .KSIZE(KSIZE), .CH_NUM(4), .OUT_W(OUT_W)) bus4 ();
   conv_mac_acc_if #(.DATA_W(DATA_W), .KSIZE(KSIZE), .CH_NUM(1), .OUT_W(OUT_W)) bus1 ();

   conv_mac_acc #(.DATA_W(DATA_W), .KSIZE(KSIZE), .CH_NUM(4), .ACC_W(ACC_W), .OUT_W(OUT_W))
      u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
   conv_mac_acc #(.DATA_W(DATA_W), .KSIZE(KSIZE), .CH_NUM(1), .ACC_W(ACC_W), .OUT_W(OUT_W))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int     n_chk = 0;
   int     n_pass = 0;
   bit     chk_en = 1'b0;
   exp_t   q4[$];
   exp_t   q1[$];
   int     last4 = 0;
   int     last1 = 0;
   int     m_ch4 = 0;
   longint m_acc4 = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
   endtask

   function automatic flat_t fill(input int v);
      flat_t f;
      for (int i = 0; i < 9; i++) f[i*8 +: 8] = 8'(v);
      return f;
   endfunction

   function automatic flat_t onehot(input int idx, input int v);
      flat_t f = '0;
      f[idx*8 +: 8] = 8'(v);
      return f;
   endfunction

   // Convolution of one beat: tap i of the window meets tap 8-i of the kernel.
   function automatic longint dot(input flat_t w, input flat_t k);
      longint s = 0;
      for (int i = 0; i < 9; i++)
         s += longint'($signed(w[i*8 +: 8])) * longint'($signed(k[(8-i)*8 +: 8]));
      return s;
   endfunction

   function automatic int post(input int x);
`ifdef CONV_MAC_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   function automatic int sat_out(input longint x);
      if (x > 32767) return post(32767);
      if (x < -32768) return post(-32768);
      return post(int'(x));
   endfunction

   // One input cycle on both instances; the model advances only on an accepted beat.
   task automatic beat(input bit v, input flat_t w, input flat_t k, input logic signed [7:0] b,
                       input bit ov4 = 1'b0, input int e4 = 0,
                       input bit ov1 = 1'b0, input int e1 = 0);
      longint d;
      bus4.in_valid = v; bus4.win_flat = w; bus4.wgt_flat = k; bus4.bias = b;
      bus1.in_valid = v; bus1.win_flat = w; bus1.wgt_flat = k; bus1.bias = b;
      if (chk_en && v) begin
         check("ch_idx4", longint'(bus4.ch_idx), m_ch4);
         check("ch_idx1", longint'(bus1.ch_idx), 0);
      end
      @(posedge clk);
      if (v && !rst) begin
         d = dot(w, k);
         if (m_ch4 == 0) m_acc4 = d + longint'(b);
         else            m_acc4 = m_acc4 + d;
         if (m_ch4 == 3) q4.push_back('{ov4 ? e4 : sat_out(m_acc4), longint'($time)});
         m_ch4 = (m_ch4 + 1) % 4;
         q1.push_back('{ov1 ? e1 : sat_out(d + longint'(b)), longint'($time)});
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, '0, '0, '0);
   endtask

   // Reset for n cycles; pending pixels and partial sums are discarded.
   task automatic do_reset(input int n, input bit v);
      rst = 1'b1;
      bus4.in_valid = v;
      bus1.in_valid = v;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         q4.delete(); q1.delete();
         m_ch4 = 0; m_acc4 = 0; last4 = 0; last1 = 0;
         chk_en = 1'b1;
         #1;
         check("rst_out_valid4", longint'(bus4.out_valid), 0);
         check("rst_out_data4", longint'(bus4.out_data), 0);
         check("rst_ch_idx4", longint'(bus4.ch_idx), 0);
         check("rst_out_valid1", longint'(bus1.out_valid), 0);
         check("rst_out_data1", longint'(bus1.out_data), 0);
      end
      rst = 1'b0;
      bus4.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
   endtask

   // Strobe checker: value, exact latency, and hold of out_data between strobes.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en && !rst) begin
         if (bus4.out_valid) begin
            if (q4.size() == 0) check("unexpected_strobe4", 1, 0);
            else begin
               e = q4.pop_front();
               check("data4", longint'(bus4.out_data), e.val);
               check("latency4", longint'($time) - PER/2, e.t + LAT*PER);
               last4 = e.val;
            end
         end else check("hold4", longint'(bus4.out_data), last4);
         if (bus1.out_valid) begin
            if (q1.size() == 0) check("unexpected_strobe1", 1, 0);
            else begin
               e = q1.pop_front();
               check("data1", longint'(bus1.out_data), e.val);
               check("latency1", longint'($time) - PER/2, e.t + LAT*PER);
               last1 = e.val;
            end
         end else check("hold1", longint'(bus1.out_data), last1);
      end
   end

   vec_t tv[7];

   initial begin
      flat_t seq;
      for (int i = 0; i < 9; i++) seq[i*8 +: 8] = 8'(i + 1);
      tv[0] = '{seq,                fill(1) ^ fill(1) | seq, 8'sd0,   165};
      tv[1] = '{fill(2),            fill(3),                 -8'sd5,  49};
      tv[2] = '{fill(-128),         fill(-128),              8'sd127, 32767};
      tv[3] = '{fill(-128),         fill(127),               -8'sd128, -32768};
      tv[4] = '{'0,                 '0,                      -8'sd1,  -1};
      tv[5] = '{onehot(0, 100),     onehot(8, 100),          8'sd0,   10000};
      tv[6] = '{onehot(0, 100),     onehot(0, 100),          8'sd3,   3};

      rst = 1'b1;
      bus4.in_valid = 1'b0; bus4.win_flat = '0; bus4.wgt_flat = '0; bus4.bias = '0;
      bus1.in_valid = 1'b0; bus1.win_flat = '0; bus1.wgt_flat = '0; bus1.bias = '0;
      #1;

      // Reset held two cycles with in_valid high.
      do_reset(2, 1'b1);
      idle(2);

      // Single-beat pixels on the CH_NUM=1 instance against hand values.
      for (int i = 0; i < 7; i++)
         beat(1'b1, tv[i].win, tv[i].wgt, tv[i].bias, 1'b0, 0, 1'b1, post(tv[i].exp));
      idle(10);
      do_reset(1, 1'b0);

      // Four channel beats separated by bubbles: one strobe of 4*54-5.
      beat(1'b1, fill(2), fill(3), -8'sd5);
      idle(2);
      beat(1'b1, fill(2), fill(3), -8'sd5);
      idle(1);
      beat(1'b1, fill(2), fill(3), -8'sd5);
      beat(1'b1, fill(2), fill(3), -8'sd5, 1'b1, 211);
      idle(10);

      // Saturation at both ends.
      for (int c = 0; c < 4; c++) beat(1'b1, fill(-128), fill(-128), 8'sd0, c == 3, 32767);
      for (int c = 0; c < 4; c++) beat(1'b1, fill(-128), fill(127), 8'sd0, c == 3, post(-32768));
      idle(10);

      // Back-to-back pixels; bias on non-first beats must be ignored.
      for (int p = 1; p <= 3; p++)
         for (int c = 0; c < 4; c++)
            beat(1'b1, fill(p), fill(1), (c == 0) ? 8'(p) : 8'sd99, c == 3, 37 * p);
      idle(10);

      // Reset mid-pixel: only the following pixel appears.
      beat(1'b1, fill(5), fill(5), 8'sd7);
      beat(1'b1, fill(5), fill(5), 8'sd7);
      do_reset(1, 1'b0);
      for (int c = 0; c < 4; c++) beat(1'b1, fill(1), fill(1), 8'sd0, c == 3, 36);
      idle(10);

      // Random beats with random bubbles against the model.
      for (int p = 0; p < 40; p++) begin
         for (int c = 0; c < 4; c++) begin
            flat_t w, k;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            if ($urandom_range(0, 4) == 0) begin
               w = fill(($urandom_range(0, 1) == 0) ? -128 : 127);
               k = fill(($urandom_range(0, 1) == 0) ? -128 : 127);
            end else begin
               w = 72'({$urandom(), $urandom(), $urandom()});
               k = 72'({$urandom(), $urandom(), $urandom()});
            end
            beat(1'b1, w, k, 8'($urandom()));
         end
      end
      idle(12);

      check("drain4", longint'(q4.size()), 0);
      check("drain1", longint'(q1.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
